// File: rtl/ysyx_22040088_pkg.sv
// rtl/ysyx_22040088_pkg.sv - shared constants and types for the ysyx_22040088 core
package ysyx_22040088_pkg;

   // IFU FSM state encoding
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_REQ    = 3'd1;
   localparam logic [2:0] ST_WAIT   = 3'd2;
   localparam logic [2:0] ST_OUT    = 3'd3;
   localparam logic [2:0] ST_COMMIT = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_REQ    = ST_REQ,
      S_WAIT   = ST_WAIT,
      S_OUT    = ST_OUT,
      S_COMMIT = ST_COMMIT
   } ifu_state_e;

   // PC loaded on reset
   localparam logic [63:0] RESET_PC = 64'h8000_0000;

   // addi x0, x0, 0 -- reserved for a future flush path
   localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/ysyx_22040088_ifu.sv
// rtl/ysyx_22040088_ifu.sv - instruction fetch unit: PC, imem request/response, decode handshake
module ysyx_22040088_ifu #(
   parameter logic [63:0] RESET_PC = ysyx_22040088_pkg::RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_addr,
   input  logic        imem_resp_valid,
   input  logic [63:0] imem_resp_data,
   input  logic        imem_resp_err,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [63:0] pc,
   output logic        fetch_fault,
   input  logic        commit_valid,
   input  logic [63:0] commit_nextpc
);
   import ysyx_22040088_pkg::*;

   ifu_state_e  state, state_n;
   logic [63:0] pc_n;
   logic [31:0] inst_n;
   logic        fault_n;

   // imem is doubleword addressed; pc[2] later selects the word
   assign imem_addr = {pc[63:3], 3'b000};

   // next-state, next-PC and instruction-register update
   always_comb begin
      state_n = state;
      pc_n    = pc;
      inst_n  = inst;
      fault_n = fetch_fault;
      case (state)
         S_IDLE: begin
            state_n = S_REQ;
         end
         S_REQ: begin
            if (pc[1:0] != 2'b00) begin
               // misaligned PC faults without touching imem
               inst_n  = 32'h0;
               fault_n = 1'b1;
               state_n = S_OUT;
            end else if (imem_req_ready) begin
               state_n = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_resp_valid) begin
               fault_n = imem_resp_err;
               if (imem_resp_err) begin
                  inst_n = 32'h0;
               end else if (pc[2]) begin
                  inst_n = imem_resp_data[63:32];
               end else begin
                  inst_n = imem_resp_data[31:0];
               end
               state_n = S_OUT;
            end
         end
         S_OUT: begin
            if (inst_ready) begin
               state_n = S_COMMIT;
            end
         end
         S_COMMIT: begin
            if (commit_valid) begin
               pc_n    = commit_nextpc;
               state_n = S_REQ;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // state, PC and output registers; valids are precomputed from next state so no input reaches an output
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         pc             <= RESET_PC;
         inst           <= 32'h0;
         fetch_fault    <= 1'b0;
         imem_req_valid <= 1'b0;
         inst_valid     <= 1'b0;
      end else begin
         state          <= state_n;
         pc             <= pc_n;
         inst           <= inst_n;
         fetch_fault    <= fault_n;
         imem_req_valid <= (state_n == S_REQ) && (pc_n[1:0] == 2'b00);
         inst_valid     <= (state_n == S_OUT);
      end
   end

endmodule

// File: tb/tb_ysyx_22040088_ifu.sv
// tb/tb_ysyx_22040088_ifu.sv - scoreboard bench for the instruction fetch unit
module tb_ysyx_22040088_ifu;

   localparam logic [63:0] RST_PC = 64'h8000_0000;
   localparam logic [63:0] DATA0  = 64'h0010_0093_0000_0513;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
      logic        fault;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_addr;
   logic        imem_resp_valid;
   logic [63:0] imem_resp_data;
   logic        imem_resp_err;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [63:0] pc;
   logic        fetch_fault;
   logic        commit_valid;
   logic [63:0] commit_nextpc;

   int   checks   = 0;
   int   failures = 0;
   int   acc_reqs = 0;
   int   exp_reqs = 0;
   exp_t sb[$];

   ysyx_22040088_ifu #(.RESET_PC(RST_PC)) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_addr       (imem_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .imem_resp_err   (imem_resp_err),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst            (inst),
      .pc              (pc),
      .fetch_fault     (fetch_fault),
      .commit_valid    (commit_valid),
      .commit_nextpc   (commit_nextpc)
   );

   always #5 clk = ~clk;

   // count accepted imem requests
   always @(posedge clk) begin
      if (!rst && imem_req_valid && imem_req_ready) acc_reqs++;
   end

   initial begin
      #500000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_fetch(input logic [63:0] epc, input int hold, input logic [63:0] data,
                           input logic err, input logic [31:0] einst, input logic efault);
      int n;
      exp_t e;
      logic [63:0] eaddr;
      eaddr = {epc[63:3], 3'b000};
      n = 0;
      while (!imem_req_valid && n < 20) begin
         step();
         n++;
      end
      chk("req_seen", 64'(imem_req_valid), 64'd1);
      chk("req_addr", imem_addr, eaddr);
      for (int i = 0; i < hold; i++) begin
         imem_req_ready = 1'b0;
         step();
         chk("req_hold_valid", 64'(imem_req_valid), 64'd1);
         chk("req_hold_addr", imem_addr, eaddr);
      end
      imem_req_ready = 1'b1;
      exp_reqs++;
      step();
      imem_req_ready = 1'b0;
      chk("req_drop", 64'(imem_req_valid), 64'd0);
      imem_resp_valid = 1'b1;
      imem_resp_data  = data;
      imem_resp_err   = err;
      e.pc = epc; e.inst = einst; e.fault = efault;
      sb.push_back(e);
      step();
      imem_resp_valid = 1'b0;
      imem_resp_err   = 1'b0;
      chk("resp_to_valid", 64'(inst_valid), 64'd1);
   endtask

   task automatic consume(input int hold);
      exp_t e;
      chk("out_valid", 64'(inst_valid), 64'd1);
      if (sb.size() == 0) begin
         chk("sb_underflow", 64'(sb.size()), 64'd1);
         e = '0;
      end else begin
         e = sb.pop_front();
      end
      chk("out_pc", pc, e.pc);
      chk("out_inst", 64'(inst), 64'(e.inst));
      chk("out_fault", 64'(fetch_fault), 64'(e.fault));
      for (int i = 0; i < hold; i++) begin
         inst_ready      = 1'b0;
         commit_valid    = 1'b1;
         commit_nextpc   = 64'hdead_0000_0000_0100;
         imem_resp_valid = 1'b1;
         imem_resp_data  = {$urandom, $urandom};
         step();
         commit_valid    = 1'b0;
         imem_resp_valid = 1'b0;
         chk("hold_valid", 64'(inst_valid), 64'd1);
         chk("hold_pc", pc, e.pc);
         chk("hold_inst", 64'(inst), 64'(e.inst));
         chk("hold_fault", 64'(fetch_fault), 64'(e.fault));
      end
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      chk("out_drop", 64'(inst_valid), 64'd0);
   endtask

   task automatic commit(input logic [63:0] npc);
      commit_valid  = 1'b1;
      commit_nextpc = npc;
      step();
      commit_valid  = 1'b0;
      chk("commit_pc", pc, npc);
      chk("commit_req", 64'(imem_req_valid), 64'(npc[1:0] == 2'b00));
      if (npc[1:0] == 2'b00) chk("commit_addr", imem_addr, {npc[63:3], 3'b000});
   endtask

   initial begin
      exp_t e;
      rst             = 1'b1;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 64'h0;
      imem_resp_err   = 1'b0;
      inst_ready      = 1'b0;
      commit_valid    = 1'b0;
      commit_nextpc   = 64'h0;
      repeat (3) step();
      chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
      chk("rst_inst_valid", 64'(inst_valid), 64'd0);
      chk("rst_inst", 64'(inst), 64'd0);
      chk("rst_fault", 64'(fetch_fault), 64'd0);
      chk("rst_pc", pc, RST_PC);

      rst = 1'b0;
      step();
      chk("first_req", 64'(imem_req_valid), 64'd1);

      // aligned fetch, lower word
      do_fetch(RST_PC, 0, DATA0, 1'b0, 32'h0000_0513, 1'b0);
      consume(0);
      commit(64'h8000_0004);

      // upper word with request and decode backpressure
      do_fetch(64'h8000_0004, 5, DATA0, 1'b0, 32'h0010_0093, 1'b0);
      consume(4);

      // misaligned PC: no imem traffic, straight to OUT
      e.pc = 64'h8000_0006; e.inst = 32'h0; e.fault = 1'b1;
      sb.push_back(e);
      commit(64'h8000_0006);
      step();
      chk("mis_valid", 64'(inst_valid), 64'd1);
      chk("mis_no_req", 64'(imem_req_valid), 64'd0);
      consume(0);
      commit(64'h8000_0008);

      // access error
      do_fetch(64'h8000_0008, 0, 64'hffff_ffff_ffff_ffff, 1'b1, 32'h0, 1'b1);
      consume(1);
      commit(64'h8000_000c);

      // fault cleared on the following good fetch
      do_fetch(64'h8000_000c, 1, 64'hdead_beef_1234_5678, 1'b0, 32'hdead_beef, 1'b0);
      consume(0);
      commit(64'h1234_5678_9abc_def0);

      // full 64-bit PC
      do_fetch(64'h1234_5678_9abc_def0, 0, 64'h0aaa_aaaa_0555_5555, 1'b0, 32'h0555_5555, 1'b0);
      consume(2);
      commit(64'h8000_0010);

      // reset while a request is outstanding, then a stale response
      chk("pre_rst_req", 64'(imem_req_valid), 64'd1);
      imem_req_ready = 1'b1;
      exp_reqs++;
      step();
      imem_req_ready = 1'b0;
      rst = 1'b1;
      step();
      chk("mid_rst_pc", pc, RST_PC);
      chk("mid_rst_valid", 64'(inst_valid), 64'd0);
      chk("mid_rst_req", 64'(imem_req_valid), 64'd0);
      rst             = 1'b0;
      imem_resp_valid = 1'b1;
      imem_resp_data  = 64'h1111_2222_3333_4444;
      step();
      imem_resp_valid = 1'b0;
      chk("stale_inst_valid", 64'(inst_valid), 64'd0);
      chk("stale_inst", 64'(inst), 64'd0);
      chk("fresh_req", 64'(imem_req_valid), 64'd1);
      chk("fresh_addr", imem_addr, RST_PC);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("fresh_hold_valid", 64'(inst_valid), 64'd0);
         chk("fresh_hold_req", 64'(imem_req_valid), 64'd1);
      end

      chk("sb_drained", 64'(sb.size()), 64'd0);
      chk("req_count", 64'(acc_reqs), 64'(exp_reqs));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ysyx_22040088_ifu.md
# ysyx_22040088_ifu

Instruction fetch unit for the ysyx_22040088 single-issue multi-cycle core. It owns the architectural PC, fetches 32-bit instructions over a 64-bit instruction-memory request/response interface, and presents each instruction to the decode stage with a valid/ready handshake. It waits for the execute stage to return the next PC (commit) before fetching again. It sits between imem and the decode stage and is the producer side of the decode stage's `inst` input.

## Interface
- `RESET_PC`, default `64'h8000_0000`: PC loaded on reset.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  imem accepts the request this cycle.
- `imem_addr`  out  64  `{pc[63:3], 3'b000}`; stable while `imem_req_valid`.
- `imem_resp_valid`  in  1  response data valid (single-cycle pulse).
- `imem_resp_data`  in  64  aligned doubleword.
- `imem_resp_err`  in  1  access fault; qualified by `imem_resp_valid`.
- `inst_valid`  out  1  `inst`/`pc`/`fetch_fault` valid toward decode.
- `inst_ready`  in  1  decode accepts the instruction.
- `inst`  out  32  fetched instruction.
- `pc`  out  64  PC of the current instruction (architectural PC).
- `fetch_fault`  out  1  instruction has a misaligned-PC or access fault; `inst` is 0.
- `commit_valid`  in  1  execute stage has retired the instruction; `commit_nextpc` valid.
- `commit_nextpc`  in  64  next PC selected by the execute stage (already resolved from `sel_nextpc`).

## Operation
- FSM states: IDLE, REQ, WAIT, OUT, COMMIT.
- IDLE: entered on reset. Moves to REQ on the next cycle.
- REQ:
  - If `pc[1:0] != 0`, no request is issued. `inst` = 0 and `fetch_fault` = 1. Next state is OUT.
  - Otherwise `imem_req_valid` = 1. On `imem_req_ready`, next state is WAIT. If not ready, hold with address stable.
- WAIT: on `imem_resp_valid`, register the instruction and the fault flag, then go to OUT.
  - `inst` = `pc[2] ? data[63:32] : data[31:0]`.
  - `fetch_fault` = `imem_resp_err`. On error, `inst` = 0.
- OUT: `inst_valid` = 1. `inst`, `pc` and `fetch_fault` hold stable until `inst_ready`. On `inst_ready`, go to COMMIT.
- COMMIT: wait for `commit_valid`. Then `pc` ← `commit_nextpc` (full 64 bits, no truncation) and go to REQ.
- Events in the wrong state are ignored:
  - `imem_resp_valid` outside WAIT.
  - `commit_valid` outside COMMIT.
  - `inst_ready` outside OUT.
- At most one outstanding imem request at any time.

## Timing
- Reset values: state = IDLE, `pc` = `RESET_PC`, `imem_req_valid` = 0, `inst_valid` = 0, `inst` = 0, `fetch_fault` = 0.
- `imem_req_valid` and `inst_valid` are registered, decoded from registered state only. No combinational path from any input to any output.
- First request: with `rst` deasserted at edge E0, `imem_req_valid` rises in the cycle after E1.
- Request/response latency:
  - Request accepted in cycle M; response can arrive at the earliest in cycle M+1.
  - Response in cycle R gives `inst_valid` = 1 in cycle R+1.
- Handshake to commit: a handshake in cycle H puts the FSM in COMMIT at H+1. `commit_valid` is sampled from cycle H+1 on.
- Commit to next fetch: commit in cycle C gives `imem_req_valid` = 1 in C+1 with the new `imem_addr`.
- Misaligned PC: REQ to OUT in one cycle, with no imem traffic.
- Reset mid-operation: `rst` overrides everything at the next edge. Any outstanding request or response is abandoned, and a late `imem_resp_valid` is ignored because the FSM is not in WAIT.

## Structure
- Shared package (`ysyx_22040088_pkg`, or the existing defines header) holds:
  - the FSM state encoding (3-bit localparams),
  - `RESET_PC`,
  - `INST_NOP` = `32'h0000_0013`, for later use by a flush extension.
- No sub-module. It is a single FSM plus a PC register and an instruction register. The PC register could become a generic enable-flop `ysyx_22040088_reg` if that module already exists.

## Test plan
- Reset, then aligned fetch: `RESET_PC` = `0x8000_0000`, `imem_req_ready` = 1, response after 1 cycle with data `0x00100093_00000513`.
  - Expect `imem_addr` = `0x8000_0000`, `inst` = `0x00000513`, `fetch_fault` = 0.
  - Expect `inst_valid` exactly 1 cycle after the response.
- Upper word and commit: `commit_nextpc` = `0x8000_0004`, same data.
  - Expect `imem_addr` = `0x8000_0000` and `inst` = `0x00100093`.
  - Expect `imem_req_valid` 1 cycle after commit.
- Backpressure:
  - Hold `imem_req_ready` = 0 for 5 cycles: address stays stable, a single request is issued.
  - Hold `inst_ready` = 0 for 4 cycles: `inst`/`pc` stay stable. `commit_valid` pulses during OUT are ignored (the `pc` output does not change).
- Misaligned PC: commit `0x8000_0006`.
  - Expect no `imem_req_valid` and `inst_valid` 1 cycle later.
  - Expect `fetch_fault` = 1, `inst` = 0, `pc` = `0x8000_0006`.
- Access error: response with `imem_resp_err` = 1.
  - Expect `fetch_fault` = 1 and `inst` = 0.
  - The next commit clears `fetch_fault` on the following fetch.
- Reset in WAIT: assert `rst` while a request is outstanding, then deliver a stale response.
  - Expect the FSM in IDLE, `pc` = `RESET_PC`, no `inst_valid`.
  - Expect a fresh request at `RESET_PC`.
